// File: rtl/sga_step_sequencer_if.sv
// ---------------------------------------------------------------------------
// sga_step_sequencer_if
//   Control/bus bundle between the game control unit, the step sequencer and
//   the snake datapath.
//
//   Signals:
//     clear      game restart request (synchronous)
//     enable     game running (1) / paused (0)
//     buttons    [3] left, [2] right, [1] up, [0] down, active-high levels
//     size       current snake length
//     direction  committed direction: 00 right, 01 left, 10 up, 11 down
//     ram_addr   body RAM address
//     ram_we     body RAM write enable
//     mux_ram    RAM write-data select: 0 previous read data, 1 new head
//     head_load  one-cycle pulse, datapath registers the next head
//     step_busy  high while a move step is in progress
//     step_done  one-cycle pulse at the end of a step
//     db_state   sequencer state encoding for debug
//
//   Modports:
//     master  the step sequencer (drives the strobes)
//     slave   the control unit / datapath side
// ---------------------------------------------------------------------------
interface sga_step_sequencer_if #(
   parameter int ADDR_W = 4
);
   logic              clear;
   logic              enable;
   logic [3:0]        buttons;
   logic [ADDR_W:0]   size;
   logic [1:0]        direction;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic              mux_ram;
   logic              head_load;
   logic              step_busy;
   logic              step_done;
   logic [2:0]        db_state;

   modport master (
      input  clear, enable, buttons, size,
      output direction, ram_addr, ram_we, mux_ram, head_load,
             step_busy, step_done, db_state
   );

   modport slave (
      output clear, enable, buttons, size,
      input  direction, ram_addr, ram_we, mux_ram, head_load,
             step_busy, step_done, db_state
   );
endinterface

// File: rtl/sga_step_sequencer.sv
// ---------------------------------------------------------------------------
// sga_step_sequencer
//   Sequences one snake move per game tick: generates the move tick,
//   arbitrates button presses into a committed direction (180-degree
//   reversals rejected), shifts the body RAM tail-to-head, then loads and
//   writes the new head. A step is bracketed by step_busy and ends with a
//   one-cycle step_done pulse.
//
//   Ports:
//     clock      system clock, rising edge
//     restart_n  asynchronous active-low reset
//     bus        sga_step_sequencer_if.master (control inputs, RAM strobes,
//                direction, busy/done handshake, debug state)
//
//   Optional build macro:
//     SGA_SPEEDUP_EN  tick period shrinks with snake length:
//                     max(TICK_DIV - N*TICK_STEP, TICK_MIN); otherwise the
//                     period is TICK_DIV.
// ---------------------------------------------------------------------------
module sga_step_sequencer #(
   parameter int MAX_SIZE  = 16,
   parameter int ADDR_W    = 4,
   parameter int TICK_DIV  = 1000
`ifdef SGA_SPEEDUP_EN
   ,
   parameter int TICK_STEP = 32,
   parameter int TICK_MIN  = 200
`endif
) (
   input  logic                  clock,
   input  logic                  restart_n,
   sga_step_sequencer_if.master  bus
);

   localparam int CNT_W = $clog2(TICK_DIV);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] WAIT_TICK = 3'd1;
   localparam logic [2:0] LATCH     = 3'd2;
   localparam logic [2:0] SHIFT_RD  = 3'd3;
   localparam logic [2:0] SHIFT_WR  = 3'd4;
   localparam logic [2:0] HEAD      = 3'd5;
   localparam logic [2:0] HEAD_WR   = 3'd6;
   localparam logic [2:0] DONE      = 3'd7;

   localparam logic [1:0] DIR_RIGHT = 2'b00;
   localparam logic [1:0] DIR_LEFT  = 2'b01;
   localparam logic [1:0] DIR_UP    = 2'b10;
   localparam logic [1:0] DIR_DOWN  = 2'b11;

   localparam logic [ADDR_W:0] MAX_N = (ADDR_W+1)'(MAX_SIZE);
   localparam logic [ADDR_W:0] ONE_N = (ADDR_W+1)'(1);

   logic [2:0]        state, state_nx;
   logic [ADDR_W-1:0] idx, idx_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [CNT_W-1:0]  period_m1;
   logic [ADDR_W:0]   n_eff;
   logic [1:0]        direction_q, pending_q;
   logic [1:0]        btn_dir;
   logic              btn_valid;
   logic              btn_reverse;

   logic [ADDR_W-1:0] ram_addr_q;
   logic              ram_we_q, mux_ram_q, head_load_q, step_busy_q, step_done_q;

   // Effective length, clamped to 1..MAX_SIZE
   always_comb begin
      if (bus.size == '0)
         n_eff = ONE_N;
      else if (bus.size > MAX_N)
         n_eff = MAX_N;
      else
         n_eff = bus.size;
   end

`ifdef SGA_SPEEDUP_EN
   logic signed [31:0] period;

   // Period follows the live length, so a growth spurt can fire the tick early
   always_comb begin
      period = TICK_DIV - $signed({1'b0, n_eff}) * TICK_STEP;
      if (period < TICK_MIN)
         period = TICK_MIN;
      period_m1 = CNT_W'(period - 1);
   end
`else
   assign period_m1 = CNT_W'(TICK_DIV - 1);
`endif

   // Button priority: left > right > up > down
   always_comb begin
      btn_valid = 1'b1;
      btn_dir   = DIR_RIGHT;
      if (bus.buttons[3])
         btn_dir = DIR_LEFT;
      else if (bus.buttons[2])
         btn_dir = DIR_RIGHT;
      else if (bus.buttons[1])
         btn_dir = DIR_UP;
      else if (bus.buttons[0])
         btn_dir = DIR_DOWN;
      else
         btn_valid = 1'b0;
   end

   // Reverse pairs differ only in bit 0
   assign btn_reverse = (btn_dir == {direction_q[1], ~direction_q[0]});

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      cnt_nx   = cnt;
      if (bus.clear) begin
         state_nx = IDLE;
         idx_nx   = '0;
         cnt_nx   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.enable) begin
                  state_nx = WAIT_TICK;
                  cnt_nx   = '0;
               end
            end
            WAIT_TICK: begin
               if (bus.enable) begin
                  if (cnt >= period_m1) begin
                     cnt_nx   = '0;
                     state_nx = LATCH;
                  end else begin
                     cnt_nx = cnt + CNT_W'(1);
                  end
               end
            end
            LATCH: begin
               idx_nx   = ADDR_W'(n_eff - ONE_N);
               state_nx = (n_eff > ONE_N) ? SHIFT_RD : HEAD;
            end
            SHIFT_RD: state_nx = SHIFT_WR;
            SHIFT_WR: begin
               idx_nx   = idx - ADDR_W'(1);
               state_nx = (idx > ADDR_W'(1)) ? SHIFT_RD : HEAD;
            end
            HEAD:     state_nx = HEAD_WR;
            HEAD_WR:  state_nx = DONE;
            DONE:     state_nx = WAIT_TICK;
            default:  state_nx = IDLE;
         endcase
      end
   end

   // Strobes are decoded from the next state so they line up with db_state
   always_ff @(posedge clock or negedge restart_n) begin
      if (!restart_n) begin
         state       <= IDLE;
         idx         <= '0;
         cnt         <= '0;
         ram_addr_q  <= '0;
         ram_we_q    <= 1'b0;
         mux_ram_q   <= 1'b0;
         head_load_q <= 1'b0;
         step_busy_q <= 1'b0;
         step_done_q <= 1'b0;
      end else begin
         state       <= state_nx;
         idx         <= idx_nx;
         cnt         <= cnt_nx;
         ram_addr_q  <= (state_nx == SHIFT_RD) ? idx_nx - ADDR_W'(1) :
                        (state_nx == SHIFT_WR) ? idx_nx : '0;
         ram_we_q    <= (state_nx == SHIFT_WR) || (state_nx == HEAD_WR);
         mux_ram_q   <= (state_nx == HEAD_WR);
         head_load_q <= (state_nx == HEAD);
         step_busy_q <= (state_nx != IDLE) && (state_nx != WAIT_TICK);
         step_done_q <= (state_nx == DONE);
      end
   end

   always_ff @(posedge clock or negedge restart_n) begin
      if (!restart_n) begin
         direction_q <= DIR_RIGHT;
         pending_q   <= DIR_RIGHT;
      end else if (bus.clear) begin
         direction_q <= DIR_RIGHT;
         pending_q   <= DIR_RIGHT;
      end else if (state != IDLE) begin
         if (state == LATCH)
            direction_q <= pending_q;
         if (btn_valid && !btn_reverse)
            pending_q <= btn_dir;
      end
   end

   assign bus.direction = direction_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_we    = ram_we_q;
   assign bus.mux_ram   = mux_ram_q;
   assign bus.head_load = head_load_q;
   assign bus.step_busy = step_busy_q;
   assign bus.step_done = step_done_q;
   assign bus.db_state  = state;

endmodule

// File: tb/tb_sga_step_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sga_step_sequencer
//   Directed-plus-random bench for sga_step_sequencer. Expected step traces
//   are built from the move rules (tail-to-head shift of N-1 pairs, head load,
//   head write, done); direction is tracked with a pending/committed model.
// ---------------------------------------------------------------------------
module tb_sga_step_sequencer;
   localparam int ADDR_W   = 4;
   localparam int MAX_SIZE = 16;
`ifdef SGA_SPEEDUP_EN
   localparam int TICK_DIV  = 1000;
   localparam int TICK_STEP = 32;
   localparam int TICK_MIN  = 200;
`else
   localparam int TICK_DIV  = 4;
`endif

   logic clock = 1'b0;
   logic restart_n;
   int   cmp_cnt = 0;
   int   mis_cnt = 0;
   int   step_no = 0;
   logic [1:0] m_dir;
   logic [1:0] m_pending;

   sga_step_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

   sga_step_sequencer #(
      .MAX_SIZE (MAX_SIZE),
      .ADDR_W   (ADDR_W),
      .TICK_DIV (TICK_DIV)
`ifdef SGA_SPEEDUP_EN
      ,
      .TICK_STEP(TICK_STEP),
      .TICK_MIN (TICK_MIN)
`endif
   ) dut (
      .clock    (clock),
      .restart_n(restart_n),
      .bus      (bus)
   );

   initial forever #5 clock = ~clock;

   function automatic int clamp_n(input int sz);
      if (sz < 1) return 1;
      if (sz > MAX_SIZE) return MAX_SIZE;
      return sz;
   endfunction

   function automatic int period_of(input int sz);
      int p;
      p = TICK_DIV;
`ifdef SGA_SPEEDUP_EN
      p = TICK_DIV - clamp_n(sz) * TICK_STEP;
      if (p < TICK_MIN) p = TICK_MIN;
`endif
      return p;
   endfunction

   function automatic logic [1:0] opposite(input logic [1:0] d);
      case (d)
         2'b00:   return 2'b01;
         2'b01:   return 2'b00;
         2'b10:   return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   // Highest-priority pressed button as a direction code, -1 if none
   function automatic int decode(input logic [3:0] b);
      if (b[3]) return 1;
      if (b[2]) return 0;
      if (b[1]) return 2;
      if (b[0]) return 3;
      return -1;
   endfunction

   function automatic logic [11:0] vec(input int st, input int addr, input bit we,
                                       input bit mux, input bit hl, input bit busy,
                                       input bit done);
      return {3'(st), 4'(addr), we, mux, hl, busy, done};
   endfunction

   function automatic logic [11:0] obs_vec();
      return {bus.db_state, bus.ram_addr, bus.ram_we, bus.mux_ram,
              bus.head_load, bus.step_busy, bus.step_done};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         mis_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic do_clear();
      bus.clear = 1'b1;
      cyc();
      bus.clear = 1'b0;
      m_dir     = 2'b00;
      m_pending = 2'b00;
      check("clear", {bus.direction, obs_vec()}, 32'd0);
   endtask

   task automatic enter_wait();
      cyc();
      check("wait_entry", obs_vec(), vec(1, 0, 0, 0, 0, 0, 0));
   endtask

   // Called with the DUT freshly in WAIT_TICK (count 0). fixed < 0 -> random
   // buttons each cycle. Optional pause: enable low for pause_len cycles.
   task automatic wait_latch(input int sz, input int fixed, input int pause_at,
                             input int pause_len);
      int n;
      int d;
      int exp_n;
      logic [3:0] b;
      n     = 0;
      exp_n = period_of(sz) + pause_len;
      bus.size = 5'(sz);
      while (!bus.step_busy && n < exp_n + 50) begin
         if (pause_len > 0 && n == pause_at) bus.enable = 1'b0;
         if (pause_len > 0 && n == pause_at + pause_len) bus.enable = 1'b1;
         b = (fixed >= 0) ? 4'(fixed) : 4'($urandom_range(0, 15));
         bus.buttons = b;
         d = decode(b);
         if (d >= 0 && 2'(d) != opposite(m_dir)) m_pending = 2'(d);
         cyc();
         n++;
      end
      bus.buttons = 4'd0;
      check($sformatf("tick_gap%0d", step_no), n, exp_n);
   endtask

   // Called with the DUT sampled in LATCH.
   task automatic run_step(input int sz, input int drop_at, input int clear_at);
      logic [11:0] q[$];
      int n;
      n = clamp_n(sz);
      q.push_back(vec(2, 0, 0, 0, 0, 1, 0));
      for (int k = n - 1; k >= 1; k--) begin
         q.push_back(vec(3, k - 1, 0, 0, 0, 1, 0));
         q.push_back(vec(4, k, 1, 0, 0, 1, 0));
      end
      q.push_back(vec(5, 0, 0, 0, 1, 1, 0));
      q.push_back(vec(6, 0, 1, 1, 0, 1, 0));
      q.push_back(vec(7, 0, 0, 0, 0, 1, 1));
      for (int i = 0; i < q.size(); i++) begin
         check($sformatf("step%0d_c%0d", step_no, i), obs_vec(), q[i]);
         if (i == 1) begin
            m_dir = m_pending;
            check($sformatf("dir%0d", step_no), bus.direction, m_dir);
            bus.size = 5'($urandom_range(0, 31));
         end
         if (i == clear_at) begin
            do_clear();
            step_no++;
            return;
         end
         if (i == drop_at) bus.enable = 1'b0;
         cyc();
      end
      check($sformatf("step%0d_end", step_no), obs_vec(), vec(1, 0, 0, 0, 0, 0, 0));
      step_no++;
   endtask

   initial begin
      int sz;
      restart_n   = 1'b0;
      bus.clear   = 1'b0;
      bus.enable  = 1'b0;
      bus.buttons = 4'd0;
      bus.size    = 5'd1;
      m_dir       = 2'b00;
      m_pending   = 2'b00;
      repeat (3) cyc();
      check("reset", {bus.direction, obs_vec()}, 32'd0);
      restart_n = 1'b1;
      repeat (2) cyc();
      check("idle_hold", {bus.direction, obs_vec()}, 32'd0);

      // Basic steps, size 1 then 3
      bus.enable = 1'b1;
      enter_wait();
      wait_latch(1, -1, -1, 0);
      run_step(1, -1, -1);
      wait_latch(3, -1, -1, 0);
      run_step(3, -1, -1);

      // Direction arbitration from a known right heading
      do_clear();
      enter_wait();
      wait_latch(2, 8, -1, 0);
      run_step(2, -1, -1);
      wait_latch(2, 3, -1, 0);
      run_step(2, -1, -1);

      // clear in the first SHIFT_WR truncates the step
      wait_latch(4, 0, -1, 0);
      run_step(4, -1, 2);
      enter_wait();

      // enable dropped in SHIFT_WR: step completes, tick frozen until re-enable
      wait_latch(4, 0, -1, 0);
      run_step(4, 2, -1);
      wait_latch(4, -1, 0, 20);
      run_step(4, -1, -1);

      // pause in the middle of the tick count
      wait_latch(5, -1, 2, 7);
      run_step(5, -1, -1);

      wait_latch(10, -1, -1, 0);
      run_step(10, -1, -1);
      wait_latch(16, -1, -1, 0);
      run_step(16, -1, -1);

      for (int r = 0; r < 6; r++) begin
         sz = $urandom_range(0, 31);
         wait_latch(sz, -1, -1, 0);
         run_step(sz, -1, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
      $finish;
   end
endmodule

// File: doc/sga_step_sequencer.md
Name: sga_step_sequencer

Overview:
- Sequences one snake move per game tick for the Snake Game Arcade datapath.
- Generates the move tick and arbitrates button presses into a committed direction, rejecting 180° reversals.
- Drives the body-position RAM through a tail-to-head shift, then loads and writes the new head.
- Sits between the game control unit and the datapath. It replaces ad-hoc RAM/head strobing with a single busy/done handshake.

Parameters:
- MAX_SIZE, 16, maximum snake length (RAM depth).
- ADDR_W, 4, RAM address width; MAX_SIZE <= 2**ADDR_W.
- TICK_DIV, 1000, clock cycles per move tick; must be >= 2.
- TICK_STEP, 32, cycles removed from the tick period per body segment (SGA_SPEEDUP_EN only).
- TICK_MIN, 200, floor on the tick period (SGA_SPEEDUP_EN only).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- restart_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous game restart; highest priority after reset.
- enable  in  1  game running (high) / paused (low).
- buttons  in  4  [3] left, [2] right, [1] up, [0] down; active-high levels.
- size  in  ADDR_W+1  current snake length, sampled at step start.
- direction  out  2  committed direction: 00 right, 01 left, 10 up, 11 down.
- ram_addr  out  ADDR_W  body RAM address.
- ram_we  out  1  body RAM write enable.
- mux_ram  out  1  RAM write-data select: 0 = previous read data, 1 = new head.
- head_load  out  1  one-cycle pulse; datapath registers the next head from direction.
- step_busy  out  1  high from LATCH through DONE inclusive.
- step_done  out  1  one-cycle pulse at end of step; datapath runs collision/apple checks.
- db_state  out  3  state encoding for debug.

Behaviour:
- Reset: state IDLE; direction = pending = 00; tick counter 0; idx 0; every output 0. All outputs are registered.
- States and encodings:
  - IDLE = 0.
  - WAIT_TICK = 1.
  - LATCH = 2.
  - SHIFT_RD = 3.
  - SHIFT_WR = 4.
  - HEAD = 5.
  - HEAD_WR = 6.
  - DONE = 7.
- State transitions:
  - IDLE -> WAIT_TICK when enable = 1. Tick counter is cleared on entry.
  - WAIT_TICK: the counter increments only while enable = 1. At count = period-1 the counter clears and the state moves to LATCH. While enable = 0 the counter holds.
  - LATCH: direction <= pending. Effective size N = clamp(size, 1, MAX_SIZE). idx <= N-1. Next state is SHIFT_RD if N > 1, else HEAD.
  - SHIFT_RD: ram_addr = idx-1, ram_we = 0.
  - SHIFT_WR: ram_addr = idx, ram_we = 1, mux_ram = 0. Then idx decrements. Next state is SHIFT_RD if the new idx >= 1, else HEAD.
  - HEAD: head_load = 1.
  - HEAD_WR: ram_addr = 0, ram_we = 1, mux_ram = 1.
  - DONE: step_done = 1, then -> WAIT_TICK.
- Step length: 2N+2 cycles from LATCH to DONE inclusive.
- Direction arbitration, every cycle outside IDLE:
  - Decode the highest-priority pressed button, priority left > right > up > down.
  - If it is not the reverse of the committed direction, pending <= decoded value; otherwise pending is unchanged.
  - Reverse pairs: 00/01 and 10/11. No button pressed leaves pending unchanged.
  - A change takes effect only at the next LATCH.
- enable falling mid-step (LATCH..DONE): the step completes unchanged. The counter then freezes in WAIT_TICK.
- clear = 1 in any state:
  - Next state IDLE; direction = pending = 00; counter 0.
  - All strobes are low from the next cycle, so a write in progress is truncated.
- size changing mid-step is ignored; N is latched in LATCH.
- Tick period without the option: TICK_DIV.

Optional Feature:
- Macro: SGA_SPEEDUP_EN.
- Defined: period = max(TICK_DIV - N_cur*TICK_STEP, TICK_MIN). N_cur = clamp(size, 1, MAX_SIZE) as read continuously during WAIT_TICK.
  - If a size change makes the counter >= period-1, the tick fires on the next cycle.
- Undefined: period is constant TICK_DIV; TICK_STEP and TICK_MIN are unused.

Test Plan:
- Reset, then enable = 1 with TICK_DIV = 4 and size = 1 -> LATCH 4 cycles after entering WAIT_TICK; head_load pulses 1 cycle; HEAD_WR writes addr 0 with mux_ram = 1; step_done follows; step_busy is high for exactly 4 cycles.
- size = 3 -> read/write address sequence (rd 1, wr 2), (rd 0, wr 1), then head write at 0; busy for 8 cycles.
- Direction = right, press left -> pending unchanged, direction stays 00. Press up+down together -> direction 10 at the next LATCH.
- enable dropped during SHIFT_WR with size = 4 -> step completes to DONE; no LATCH occurs while enable = 0; after re-enable the tick resumes from the frozen count.
- clear asserted in SHIFT_WR -> IDLE next cycle, ram_we = 0, direction = 00, db_state = 0.
- With SGA_SPEEDUP_EN, TICK_DIV = 1000, TICK_STEP = 32, TICK_MIN = 200: size = 10 -> tick period 680 cycles; size = 16 -> period 488.
